// File: rtl/rr_arb_8.sv
// rr_arb_8 -- 8-way round-robin arbiter with a per-grant hold timeout.
//
// Request/grant protocol: a requester raises req[i] and keeps it high for
// as long as it wants the resource. When it sees grant[i] high it owns the
// resource until it lowers req[i] (release) or until it has held the grant
// for TIMEOUT consecutive cycles (forced release). After a forced release
// the resource moves to the next requester in round-robin order, or back to
// the same one if it is the only one asking. Request changes made during a
// grant are only looked at when the grant ends.
//
// Ports:
//   sys_clk        clock; all logic on the rising edge
//   sys_rst        synchronous active-high reset
//   req[7:0]       request lines, bit i = requester i
//   grant[7:0]     registered one-hot grant
//   grant_idx[2:0] registered index of the current or last winner
//   grant_vld      registered, high while a grant is active
//   timeout_pulse  registered, high in the first cycle of a grant that
//                  follows a forced release
//   dbg_state      current FSM state (0 = IDLE, 1 = GRANT)
module rr_arb_8 #(
    parameter int TIMEOUT = 16
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic [7:0] req,
    output logic [7:0] grant,
    output logic [2:0] grant_idx,
    output logic       grant_vld,
    output logic       timeout_pulse,
    output logic       dbg_state
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    localparam logic [7:0] HOLD_MAX = 8'(TIMEOUT);

    state_t     state_q, state_d;
    logic [7:0] grant_q, grant_d;
    logic [2:0] idx_q, idx_d;
    logic       vld_q, vld_d;
    logic       pulse_q, pulse_d;
    logic [7:0] cnt_q, cnt_d;

    logic [2:0] winner;
    logic       release_now;
    logic       timeout_now;

    // Scan upward starting one past the last winner; the last winner itself
    // is examined last so a lone requester can be re-granted.
    always_comb begin
        winner = idx_q;
        for (int k = 8; k >= 1; k--) begin
            if (req[idx_q + 3'(k)]) begin
                winner = idx_q + 3'(k);
            end
        end
    end

    assign release_now = !req[idx_q];
    assign timeout_now = req[idx_q] && (cnt_q == HOLD_MAX);

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        idx_d   = idx_q;
        vld_d   = vld_q;
        pulse_d = 1'b0;
        cnt_d   = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (req != 8'h00) begin
                    state_d = ST_GRANT;
                    idx_d   = winner;
                    grant_d = 8'h01 << winner;
                    vld_d   = 1'b1;
                    cnt_d   = 8'd1;
                end else begin
                    grant_d = 8'h00;
                    vld_d   = 1'b0;
                end
            end
            ST_GRANT: begin
                // Release takes priority over timeout, so a simultaneous
                // release never raises timeout_pulse.
                if (release_now) begin
                    if (req != 8'h00) begin
                        idx_d   = winner;
                        grant_d = 8'h01 << winner;
                        cnt_d   = 8'd1;
                    end else begin
                        state_d = ST_IDLE;
                        grant_d = 8'h00;
                        vld_d   = 1'b0;
                        cnt_d   = 8'd0;
                    end
                end else if (timeout_now) begin
                    idx_d   = winner;
                    grant_d = 8'h01 << winner;
                    cnt_d   = 8'd1;
                    pulse_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = 8'h00;
                vld_d   = 1'b0;
                cnt_d   = 8'd0;
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q <= ST_IDLE;
            grant_q <= 8'h00;
            idx_q   <= 3'd7;
            vld_q   <= 1'b0;
            pulse_q <= 1'b0;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            idx_q   <= idx_d;
            vld_q   <= vld_d;
            pulse_q <= pulse_d;
            cnt_q   <= cnt_d;
        end
    end

    assign grant         = grant_q;
    assign grant_idx     = idx_q;
    assign grant_vld     = vld_q;
    assign timeout_pulse = pulse_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_rr_arb_8.sv
// tb_rr_arb_8 -- self-checking bench for rr_arb_8 with TIMEOUT = 4.
// Directed scenarios followed by random request traffic, all compared
// against a behavioural model of owner/hold-time/round-robin order.
module tb_rr_arb_8;

    localparam int TO        = 4;
    localparam int STARVE    = 7 * TO + 1;
    localparam int N_RANDOM  = 2000;

    logic       sys_clk;
    logic       sys_rst;
    logic [7:0] req;
    logic [7:0] grant;
    logic [2:0] grant_idx;
    logic       grant_vld;
    logic       timeout_pulse;
    logic       dbg_state;

    int n_cmp;
    int n_err;

    // ---------------- clock / reset ----------------
    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    rr_arb_8 #(.TIMEOUT(TO)) dut (
        .sys_clk       (sys_clk),
        .sys_rst       (sys_rst),
        .req           (req),
        .grant         (grant),
        .grant_idx     (grant_idx),
        .grant_vld     (grant_vld),
        .timeout_pulse (timeout_pulse),
        .dbg_state     (dbg_state)
    );

    // ---------------- reference model ----------------
    // Tracks who owns the resource, how long they have held it and the
    // last winner, and applies the arbitration rules once per clock edge.
    bit       m_busy;
    int       m_owner;
    int       m_held;
    bit       m_pulse;
    int       wait_cyc [8];

    function automatic int next_owner(input logic [7:0] r, input int last);
        int w;
        w = last;
        for (int off = 8; off >= 1; off--) begin
            if (r[(last + off) % 8]) w = (last + off) % 8;
        end
        return w;
    endfunction

    always @(posedge sys_clk) begin
        if (sys_rst) begin
            m_busy  = 1'b0;
            m_owner = 7;
            m_held  = 0;
            m_pulse = 1'b0;
        end else if (!m_busy) begin
            m_pulse = 1'b0;
            if (req != 8'h00) begin
                m_owner = next_owner(req, m_owner);
                m_busy  = 1'b1;
                m_held  = 1;
            end
        end else if (!req[m_owner]) begin
            m_pulse = 1'b0;
            if (req != 8'h00) begin
                m_owner = next_owner(req, m_owner);
                m_held  = 1;
            end else begin
                m_busy = 1'b0;
                m_held = 0;
            end
        end else if (m_held == TO) begin
            m_owner = next_owner(req, m_owner);
            m_held  = 1;
            m_pulse = 1'b1;
        end else begin
            m_held  = m_held + 1;
            m_pulse = 1'b0;
        end
    end

    // ---------------- scoreboard ----------------
    logic [7:0] exp_q [$];

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Compares every output with the model; also verifies no requester
    // waits longer than the starvation bound.
    task automatic check_model();
        logic [7:0] eg;
        int worst;
        eg = m_busy ? (8'h01 << m_owner) : 8'h00;
        check("grant", grant, eg);
        check("grant_idx", {5'd0, grant_idx}, 8'(m_owner));
        check("grant_vld", {7'd0, grant_vld}, {7'd0, m_busy});
        check("timeout_pulse", {7'd0, timeout_pulse}, {7'd0, m_pulse});
        check("dbg_state", {7'd0, dbg_state}, {7'd0, m_busy});
        worst = 0;
        for (int i = 0; i < 8; i++) begin
            if (sys_rst || !req[i] || grant[i]) wait_cyc[i] = 0;
            else wait_cyc[i] = wait_cyc[i] + 1;
            if (wait_cyc[i] > worst) worst = wait_cyc[i];
        end
        n_cmp++;
        assert (worst <= STARVE) else begin
            n_err++;
            $error("FAIL starvation observed_wait=%0d limit=%0d", worst, STARVE);
        end
    endtask

    // ---------------- driver ----------------
    // Applies inputs at a falling edge; after the next rising edge the
    // outputs are compared at the following falling edge.
    task automatic drive(input logic [7:0] r, input logic rst);
        req     = r;
        sys_rst = rst;
        @(negedge sys_clk);
        check_model();
    endtask

    // Pops one expected grant value pushed by a directed scenario.
    task automatic expect_grant(input string tag);
        logic [7:0] e;
        e = exp_q.pop_front();
        check(tag, grant, e);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] r;
        n_cmp   = 0;
        n_err   = 0;
        req     = 8'h00;
        sys_rst = 1'b1;
        for (int i = 0; i < 8; i++) wait_cyc[i] = 0;
        @(negedge sys_clk);

        // Reset state
        drive(8'h00, 1'b1);
        check("rst_grant", grant, 8'h00);
        check("rst_idx", {5'd0, grant_idx}, 8'd7);
        check("rst_vld", {7'd0, grant_vld}, 8'd0);
        check("rst_pulse", {7'd0, timeout_pulse}, 8'd0);

        // req=81 after reset: scan starts at bit 0
        drive(8'h81, 1'b0);
        check("first_grant", grant, 8'h01);
        check("first_idx", {5'd0, grant_idx}, 8'd0);
        check("first_vld", {7'd0, grant_vld}, 8'd1);

        // Drop req[0]: bit 7 wins next cycle with no gap
        drive(8'h81, 1'b0);
        drive(8'h80, 1'b0);
        check("release_grant", grant, 8'h80);
        check("release_idx", {5'd0, grant_idx}, 8'd7);
        check("release_pulse", {7'd0, timeout_pulse}, 8'd0);

        // Two persistent requesters alternate every TO cycles
        drive(8'h00, 1'b1);
        for (int k = 0; k < 4 * TO; k++) exp_q.push_back(((k / TO) % 2) ? 8'h04 : 8'h01);
        for (int k = 0; k < 4 * TO; k++) begin
            drive(8'h05, 1'b0);
            expect_grant("alt_grant");
            check("alt_pulse", {7'd0, timeout_pulse}, (k > 0 && k % TO == 0) ? 8'd1 : 8'd0);
        end

        // Single persistent requester: grant never drops, pulse every TO
        drive(8'h00, 1'b1);
        for (int k = 0; k < 3 * TO; k++) begin
            drive(8'h10, 1'b0);
            check("solo_grant", grant, 8'h10);
            check("solo_pulse", {7'd0, timeout_pulse}, (k > 0 && k % TO == 0) ? 8'd1 : 8'd0);
        end

        // Wrap-around scan: idx 6 released with req=03
        drive(8'h00, 1'b1);
        drive(8'h40, 1'b0);
        check("wrap_setup", {5'd0, grant_idx}, 8'd6);
        drive(8'h03, 1'b0);
        check("wrap_grant", grant, 8'h01);

        // Reset mid-grant, then a fresh request
        drive(8'hff, 1'b0);
        drive(8'hff, 1'b1);
        check("midrst_grant", grant, 8'h00);
        check("midrst_vld", {7'd0, grant_vld}, 8'd0);
        check("midrst_idx", {5'd0, grant_idx}, 8'd7);
        drive(8'h80, 1'b0);
        check("post_rst_grant", grant, 8'h80);

        // Random traffic: requests mostly persist so timeouts occur
        r = 8'h00;
        for (int k = 0; k < N_RANDOM; k++) begin
            if ($urandom_range(0, 3) == 0) r = 8'($urandom_range(0, 255));
            drive(r, ($urandom_range(0, 99) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
